// File: rtl/data_ram_be_if.sv
// data_ram_be_if: CPU-side load/store bus of the byte-enabled data RAM.
interface data_ram_be_if #(parameter int ADDR_W = 10);
  logic [ADDR_W+1:0] addr;
  logic [1:0] size;
  logic sext;
  logic we;
  logic [31:0] d;
  logic [31:0] q;
  logic busy;
  logic acc_err;
  logic err_sticky;
  modport master(output addr, size, sext, we, d, input q, busy, acc_err, err_sticky);
  modport slave(input addr, size, sext, we, d, output q, busy, acc_err, err_sticky);
endinterface

// File: rtl/data_ram_be.sv
// data_ram_be: word RAM with lane-enabled byte/half/word stores, extending loads and a post-reset clear sequencer.
module data_ram_be #(
  parameter int ADDR_W = 10,
  parameter bit INIT_CLEAR = 1
) (
  input logic clk,
  input logic rst,
  data_ram_be_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] clr_cnt;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] w;
  logic [1:0] lane;
  logic [3:0] be;
  logic [31:0] wd, rw;
  logic [7:0] b;
  logic [15:0] h;
  logic err, busy, wr;
  always_comb begin
    state_n = state;
    if (state == CLEAR && clr_cnt == LAST) state_n = READY;
  end
  always_ff @(posedge clk) begin
    state <= rst ? (INIT_CLEAR ? CLEAR : READY) : state_n;
    clr_cnt <= rst ? '0 : busy ? clr_cnt + 1'b1 : clr_cnt;
    bus.err_sticky <= rst ? 1'b0 : (!busy && bus.we && err) ? 1'b1 : bus.err_sticky;
  end
  always_comb begin
    w = bus.addr[ADDR_W+1:2];
    lane = bus.addr[1:0];
    busy = state == CLEAR;
    err = (bus.size == 2'b11) | (bus.size == 2'b01 & lane[0]) | (bus.size == 2'b10 & lane != 2'b00);
    wr = !rst && !busy && bus.we && !err;
    be = bus.size == 2'b00 ? 4'b0001 << lane : bus.size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = bus.size == 2'b00 ? {4{bus.d[7:0]}} : bus.size == 2'b01 ? {2{bus.d[15:0]}} : bus.d;
    rw = mem[w];
    b = rw[{lane, 3'b000} +: 8];
    h = lane[1] ? rw[31:16] : rw[15:0];
    bus.q = (busy || err) ? 32'h0 :
            bus.size == 2'b00 ? {{24{bus.sext & b[7]}}, b} :
            bus.size == 2'b01 ? {{16{bus.sext & h[15]}}, h} : rw;
    bus.busy = busy;
    bus.acc_err = err;
  end
  always_ff @(posedge clk) begin
    if (!rst && busy) mem[clr_cnt[ADDR_W-1:0]] <= 32'h0;
    for (int i = 0; i < 4; i++)
      if (wr && be[i]) mem[w][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_data_ram_be.sv
// tb_data_ram_be: directed vector table plus clear/reset sequences for data_ram_be (ADDR_W=4).
module tb_data_ram_be;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  int n;
  always #5 clk = ~clk;
  data_ram_be_if #(.ADDR_W(4)) bus();
  data_ram_be #(.ADDR_W(4), .INIT_CLEAR(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic we; logic [5:0] addr; logic [1:0] size; logic sext;
    logic [31:0] d; logic [31:0] q; logic err; logic sticky;
  } vec_t;
  vec_t v[20];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [5:0] addr, input logic [1:0] size, input logic sext, input logic [31:0] d);
    bus.we = we; bus.addr = addr; bus.size = size; bus.sext = sext; bus.d = d;
    #1;
  endtask
  task automatic count_busy(input string name);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (n == 3) drive(1, 6'h00, 2'b10, 0, 32'hDEADBEEF);
      if (n == 4) drive(0, 6'h3C, 2'b10, 0, 32'h0);
      if (n == 5) check({name, "_q_busy"}, bus.q, 32'h0);
      tick;
      n++;
    end
    check({name, "_edges"}, n, 16);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = '{0, 6'h00, 2'b10, 0, 32'h0,        32'h0,        0, 0};
    v[1]  = '{1, 6'h08, 2'b10, 0, 32'h8899AABB, 32'h0,        0, 0};
    v[2]  = '{0, 6'h08, 2'b00, 0, 32'h0,        32'h000000BB, 0, 0};
    v[3]  = '{0, 6'h09, 2'b00, 0, 32'h0,        32'h000000AA, 0, 0};
    v[4]  = '{0, 6'h0A, 2'b00, 0, 32'h0,        32'h00000099, 0, 0};
    v[5]  = '{0, 6'h0B, 2'b00, 0, 32'h0,        32'h00000088, 0, 0};
    v[6]  = '{0, 6'h0B, 2'b00, 1, 32'h0,        32'hFFFFFF88, 0, 0};
    v[7]  = '{1, 6'h0A, 2'b01, 0, 32'h00001234, 32'h00008899, 0, 0};
    v[8]  = '{0, 6'h08, 2'b10, 0, 32'h0,        32'h1234AABB, 0, 0};
    v[9]  = '{0, 6'h0A, 2'b01, 1, 32'h0,        32'h00001234, 0, 0};
    v[10] = '{0, 6'h08, 2'b01, 1, 32'h0,        32'hFFFFAABB, 0, 0};
    v[11] = '{0, 6'h08, 2'b00, 1, 32'h0,        32'hFFFFFFBB, 0, 0};
    v[12] = '{1, 6'h09, 2'b01, 0, 32'h0000FFFF, 32'h0,        1, 1};
    v[13] = '{1, 6'h0E, 2'b10, 0, 32'h11111111, 32'h0,        1, 1};
    v[14] = '{1, 6'h08, 2'b11, 0, 32'h22222222, 32'h0,        1, 1};
    v[15] = '{0, 6'h08, 2'b10, 0, 32'h0,        32'h1234AABB, 0, 1};
    v[16] = '{0, 6'h0C, 2'b10, 0, 32'h0,        32'h0,        0, 1};
    v[17] = '{1, 6'h0D, 2'b00, 0, 32'h0000005A, 32'h0,        0, 1};
    v[18] = '{0, 6'h0C, 2'b10, 0, 32'h0,        32'h00005A00, 0, 1};
    v[19] = '{0, 6'h0C, 2'b01, 1, 32'h0,        32'h00005A00, 0, 1};
    drive(0, 6'h3C, 2'b10, 0, 32'h0);
    tick;
    tick;
    check("rst_busy", bus.busy, 1);
    check("rst_sticky", bus.err_sticky, 0);
    check("rst_q", bus.q, 0);
    rst = 0;
    count_busy("clear");
    drive(0, 6'h00, 2'b10, 0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 6'(i * 4), 2'b10, 0, 32'h0);
      check($sformatf("zero_w%0d", i), bus.q, 32'h0);
    end
    for (int i = 0; i < 20; i++) begin
      drive(v[i].we, v[i].addr, v[i].size, v[i].sext, v[i].d);
      check($sformatf("v%0d_q", i), bus.q, v[i].q);
      check($sformatf("v%0d_err", i), bus.acc_err, v[i].err);
      tick;
      check($sformatf("v%0d_sticky", i), bus.err_sticky, v[i].sticky);
    end
    drive(1, 6'h20, 2'b10, 0, 32'hCAFEF00D);
    tick;
    drive(0, 6'h20, 2'b10, 0, 32'h0);
    check("w20_before", bus.q, 32'hCAFEF00D);
    rst = 1;
    tick;
    rst = 0;
    check("sticky_cleared", bus.err_sticky, 0);
    for (int i = 0; i < 7; i++) tick;
    check("midclear_busy", bus.busy, 1);
    rst = 1;
    tick;
    rst = 0;
    count_busy("reclear");
    drive(0, 6'h20, 2'b10, 0, 32'h0);
    check("w20_after", bus.q, 32'h0);
    drive(0, 6'h00, 2'b10, 0, 32'h0);
    check("w00_after", bus.q, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
